jk_excite_gen: RTL and testbench
================================

# jk_excite_gen

Drive-side companion to the JK flip-flop bank. Accepts a target state word over a valid/ready handshake and computes the J/K excitation that moves an external bank of WIDTH JK flip-flops from its present state to the target in exactly one clock edge. It keeps a shadow copy of the bank state and optionally checks the bank's Q feedback afterwards, flagging any bit that failed to reach its target. It sits between a control sequencer and the JK register bank, on the same clock.

## Interface
- WIDTH, 4: number of JK flip-flops driven; legal range 1..32.
- ENCODE, 0: excitation policy; 0 = forced (J=t, K=~t); 1 = minimal (J=K=t^s).
- CHECK_EN, 1: 1 = sample and compare q_fb after each drive; 0 = no check.
- clk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- tgt_valid  in  1  target word offered.
- tgt_ready  out  1  block can accept a target.
- tgt_data  in  WIDTH  target state word.
- j  out  WIDTH  J drive to the bank; registered.
- k  out  WIDTH  K drive to the bank; registered.
- drv_strobe  out  1  j/k carry a real excitation this cycle.
- q_fb  in  WIDTH  Q outputs of the bank.
- done  out  1  one-cycle pulse when a transfer completes.
- mismatch  out  1  sticky error flag.
- mis_bits  out  WIDTH  XOR of target and q_fb from the last failing check.
- shadow  out  WIDTH  modelled bank state.
- err_clr  in  1  clears mismatch and mis_bits.

## Operation
- States: IDLE, DRIVE, CHECK. CHECK exists only when CHECK_EN=1.
- tgt_ready = (state==IDLE) & rst_n.
- Accept condition: tgt_valid & tgt_ready. On accept, the block latches tgt_data into tgt_reg, computes j/k, and moves to DRIVE.
- Encoding, per bit i, with s = shadow[i] and t = tgt_data[i]:
  - ENCODE=0: j=t, k=~t.
  - ENCODE=1: j=k=t^s. An unchanged bit gets 00 (hold); a changed bit gets 11 (toggle).
- DRIVE lasts one cycle, with drv_strobe=1. The bank captures j/k on the edge that ends DRIVE, and on that same edge shadow loads tgt_reg.
- Next state after DRIVE: CHECK if CHECK_EN=1, otherwise IDLE with done=1.
- CHECK lasts one cycle, compares q_fb against tgt_reg, then goes to IDLE with done=1.
  - If they differ: mismatch<=1, mis_bits<=q_fb^tgt_reg, shadow<=q_fb (resynchronise).
  - If they match: mismatch and mis_bits are unchanged.
- j=k=0 and drv_strobe=0 in every cycle that is not DRIVE, so the bank holds.
- err_clr clears mismatch and mis_bits to 0. If a failing CHECK coincides with err_clr, the set wins.
- tgt_data is ignored when the handshake does not complete; tgt_valid asserted in DRIVE or CHECK has no effect.

## Timing
- Reset (rst_n low at an edge) sets:
  - state=IDLE;
  - j=k=0, drv_strobe=0, done=0;
  - shadow=0, mismatch=0, mis_bits=0;
  - tgt_ready=0 while rst_n is low, and 1 in the first cycle after release.
- Accept in cycle T gives:
  - DRIVE with j/k valid in T+1;
  - bank Q updated in T+2.
- Completion:
  - CHECK_EN=1: CHECK in T+2; done=1 and tgt_ready=1 in T+3; mismatch visible in T+3.
  - CHECK_EN=0: done=1 and tgt_ready=1 in T+2.
- Throughput:
  - CHECK_EN=1: one target per 3 cycles.
  - CHECK_EN=0: one target per 2 cycles.
  - Back-to-back works by holding tgt_valid high.
- Reset asserted mid-DRIVE or mid-CHECK:
  - next cycle returns to IDLE with j=k=0 and no done pulse;
  - shadow=0, even though the bank may already have updated.
- A target equal to shadow with ENCODE=1 still runs the full sequence, with j=k=0 during DRIVE and drv_strobe=1.

## Test plan
- Reset release, WIDTH=4, ENCODE=0, CHECK_EN=1; accept 4'b1010 with an ideal JK model on q_fb -> T+1: j=1010, k=0101, drv_strobe=1; T+3: done=1, shadow=1010, mismatch=0.
- ENCODE=1, shadow=1010, accept 4'b0110 -> DRIVE shows j=k=1100; the model reaches 0110; no mismatch; shadow=0110.
- Fault injection: q_fb bit 0 stuck at 1, target 0000 from shadow 0001 -> mismatch=1 and mis_bits=0001 in T+3, shadow=0001. Then err_clr=1 for one cycle -> mismatch=0, mis_bits=0.
- tgt_valid held high with three targets queued, CHECK_EN=1 -> accepts exactly every 3 cycles; j/k are 0 outside DRIVE; done pulses 3 cycles apart. Repeat with CHECK_EN=0 -> accepts every 2 cycles.
- rst_n pulled low during DRIVE -> next cycle: j=k=0, done=0, shadow=0, tgt_ready=0; tgt_ready=1 one cycle after release.
- err_clr asserted in the same cycle as a failing CHECK -> mismatch=1 afterwards, and mis_bits holds the new XOR.

Source files
------------

// File: rtl/jk_excite_gen_if.sv
// Target-word handshake between the control sequencer
// and the JK excitation generator.
interface jk_excite_gen_if #(
  parameter int WIDTH = 4
);
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;

  modport master (
    output tgt_valid,
    output tgt_data,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid,
    input  tgt_data,
    output tgt_ready
  );
endinterface

// File: rtl/jk_excite_gen.sv
// JK excitation generator: turns a target word into one
// cycle of J/K drive and optionally verifies the bank Q.
module jk_excite_gen #(
  parameter int WIDTH    = 4,
  parameter int ENCODE   = 0,
  parameter int CHECK_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  jk_excite_gen_if.slave   tgt,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             drv_strobe,
  input  logic [WIDTH-1:0] q_fb,
  output logic             done,
  output logic             mismatch,
  output logic [WIDTH-1:0] mis_bits,
  output logic [WIDTH-1:0] shadow,
  input  logic             err_clr
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] tgt_reg;
  logic [WIDTH-1:0] j_nxt;
  logic [WIDTH-1:0] k_nxt;
  logic [WIDTH-1:0] enc_j;
  logic [WIDTH-1:0] enc_k;
  logic             strobe_nxt;
  logic             done_nxt;
  logic             accept;
  logic             fail;

  assign tgt.tgt_ready = (state == IDLE) & rst_n;
  assign accept = tgt.tgt_valid & tgt.tgt_ready;
  assign fail = (state == CHECK) && (q_fb != tgt_reg);

  // Minimal policy toggles only the bits that change.
  assign enc_j = (ENCODE != 0)
               ? (tgt.tgt_data ^ shadow)
               : tgt.tgt_data;
  assign enc_k = (ENCODE != 0)
               ? (tgt.tgt_data ^ shadow)
               : ~tgt.tgt_data;

  always_comb begin
    state_nxt  = state;
    j_nxt      = '0;
    k_nxt      = '0;
    strobe_nxt = 1'b0;
    done_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt  = DRIVE;
          j_nxt      = enc_j;
          k_nxt      = enc_k;
          strobe_nxt = 1'b1;
        end
      end
      DRIVE: begin
        if (CHECK_EN != 0) begin
          state_nxt = CHECK;
        end else begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      CHECK: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      j          <= '0;
      k          <= '0;
      drv_strobe <= 1'b0;
      done       <= 1'b0;
      tgt_reg    <= '0;
      shadow     <= '0;
      mismatch   <= 1'b0;
      mis_bits   <= '0;
    end else begin
      state      <= state_nxt;
      j          <= j_nxt;
      k          <= k_nxt;
      drv_strobe <= strobe_nxt;
      done       <= done_nxt;
      if (accept) begin
        tgt_reg <= tgt.tgt_data;
      end
      if (state == DRIVE) begin
        shadow <= tgt_reg;
      end
      // A failing check beats a simultaneous clear.
      if (fail) begin
        mismatch <= 1'b1;
        mis_bits <= q_fb ^ tgt_reg;
        shadow   <= q_fb;
      end else if (err_clr) begin
        mismatch <= 1'b0;
        mis_bits <= '0;
      end
    end
  end

endmodule

// File: tb/tb_jk_excite_gen.sv
// Randomised bench for jk_excite_gen: three parameter mixes
// driving ideal JK banks with optional stuck-at faults.
module tb_jk_excite_gen;

  localparam int W = 4;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [W-1:0] tdat [N];
  logic [W-1:0] jv   [N];
  logic [W-1:0] kv   [N];
  logic [W-1:0] qfb  [N];
  logic [W-1:0] misb [N];
  logic [W-1:0] shd  [N];
  logic [W-1:0] s1   [N];
  logic [W-1:0] s0   [N];
  logic         vld  [N];
  logic         rdy  [N];
  logic         strb [N];
  logic         dn   [N];
  logic         mis  [N];
  logic         eclr [N];

  logic [W-1:0] m_sh [N];
  logic [W-1:0] m_mb [N];
  logic         m_mis[N];

  int n_vec = 0;
  int n_err = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [W-1:0] bq;
    jk_excite_gen_if #(.WIDTH(W)) tif ();
    assign tif.tgt_valid = vld[g];
    assign tif.tgt_data  = tdat[g];
    assign rdy[g] = tif.tgt_ready;
    assign qfb[g] = (bq | s1[g]) & ~s0[g];
    initial bq = '0;
    // ideal JK bank: Q+ = J~Q | ~K Q
    always @(posedge clk)
      if (rst_n) bq <= (jv[g] & ~bq) | (~kv[g] & bq);
    jk_excite_gen #(
      .WIDTH   (W),
      .ENCODE  (g == 1 ? 1 : 0),
      .CHECK_EN(g == 2 ? 0 : 1)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tgt       (tif.slave),
      .j         (jv[g]),
      .k         (kv[g]),
      .drv_strobe(strb[g]),
      .q_fb      (qfb[g]),
      .done      (dn[g]),
      .mismatch  (mis[g]),
      .mis_bits  (misb[g]),
      .shadow    (shd[g]),
      .err_clr   (eclr[g])
    );
  end

  function automatic bit enc(int g);
    return g == 1;
  endfunction

  function automatic bit chkon(int g);
    return g != 2;
  endfunction

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_chk(int g, string tag);
    chk({tag, "_j"}, jv[g], 0);
    chk({tag, "_k"}, kv[g], 0);
    chk({tag, "_strb"}, strb[g], 0);
  endtask

  task automatic state_chk(int g, string tag);
    chk({tag, "_shadow"}, shd[g], m_sh[g]);
    chk({tag, "_mismatch"}, mis[g], m_mis[g]);
    chk({tag, "_mis_bits"}, misb[g], m_mb[g]);
  endtask

  // Starts at the falling edge of the accept cycle T and
  // returns at the falling edge of the completion cycle.
  task automatic txn(int g, logic [W-1:0] t, bit hold,
                     bit clr_chk);
    logic [W-1:0] ej, ek, fb;
    vld[g]  = 1'b1;
    tdat[g] = t;
    chk("ready_T", rdy[g], 1);
    ej = enc(g) ? (t ^ m_sh[g]) : t;
    ek = enc(g) ? (t ^ m_sh[g]) : ~t;
    @(negedge clk);
    if (!hold) vld[g] = 1'b0;
    tdat[g] = W'($urandom);
    chk("drive_j", jv[g], ej);
    chk("drive_k", kv[g], ek);
    chk("drive_strb", strb[g], 1);
    chk("drive_ready", rdy[g], 0);
    chk("drive_done", dn[g], 0);
    @(negedge clk);
    if (chkon(g)) begin
      idle_chk(g, "check");
      chk("check_done", dn[g], 0);
      chk("check_ready", rdy[g], 0);
      chk("check_shadow", shd[g], t);
      fb = qfb[g];
      eclr[g] = clr_chk;
      @(negedge clk);
      eclr[g] = 1'b0;
      if (fb !== t) begin
        m_mis[g] = 1'b1;
        m_mb[g]  = fb ^ t;
        m_sh[g]  = fb;
      end else begin
        if (clr_chk) begin
          m_mis[g] = 1'b0;
          m_mb[g]  = '0;
        end
        m_sh[g] = t;
      end
    end else begin
      m_sh[g] = t;
    end
    chk("done_pulse", dn[g], 1);
    chk("done_ready", rdy[g], 1);
    idle_chk(g, "done");
    state_chk(g, "done");
  endtask

  task automatic clr(int g);
    eclr[g] = 1'b1;
    @(negedge clk);
    eclr[g] = 1'b0;
    m_mis[g] = 1'b0;
    m_mb[g]  = '0;
    chk("clr_mismatch", mis[g], 0);
    chk("clr_mis_bits", misb[g], 0);
    chk("clr_done", dn[g], 0);
  endtask

  task automatic reset_all();
    for (int g = 0; g < N; g++) begin
      m_sh[g]  = '0;
      m_mb[g]  = '0;
      m_mis[g] = 1'b0;
    end
  endtask

  task automatic rst_mid(int g, logic [W-1:0] t);
    vld[g]  = 1'b1;
    tdat[g] = t;
    @(negedge clk);
    vld[g] = 1'b0;
    chk("rstmid_strb", strb[g], 1);
    rst_n = 1'b0;
    @(negedge clk);
    reset_all();
    idle_chk(g, "rstmid");
    chk("rstmid_done", dn[g], 0);
    chk("rstmid_ready", rdy[g], 0);
    state_chk(g, "rstmid");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_release_ready", rdy[g], 1);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < N; g++) begin
      vld[g] = 1'b0; tdat[g] = '0; eclr[g] = 1'b0;
      s1[g] = '0; s0[g] = '0;
    end
    reset_all();
    @(negedge clk);
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      idle_chk(g, "reset");
      chk("reset_done", dn[g], 0);
      chk("reset_ready", rdy[g], 0);
      state_chk(g, "reset");
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < N; g++)
      chk("release_ready", rdy[g], 1);

    txn(0, 4'b1010, 0, 0);
    txn(1, 4'b1010, 0, 0);
    txn(1, 4'b0110, 0, 0);
    txn(1, 4'b0110, 0, 0);

    txn(0, 4'b0001, 0, 0);
    s1[0] = 4'b0001;
    txn(0, 4'b0000, 0, 0);
    clr(0);
    txn(0, 4'b0000, 0, 1);
    s1[0] = '0;
    clr(0);

    for (int g = 0; g < N; g += 2) begin
      txn(g, 4'b0011, 1, 0);
      txn(g, 4'b1100, 1, 0);
      txn(g, 4'b0101, 0, 0);
    end

    rst_mid(0, 4'b1111);
    txn(0, 4'b1001, 0, 0);

    for (int g = 0; g < N; g++) begin
      for (int n = 0; n < 25; n++) begin
        bit hold;
        hold = (n != 24) && ($urandom_range(0, 1) == 1);
        s1[g] = '0;
        s0[g] = '0;
        if (chkon(g) && $urandom_range(0, 4) == 0) begin
          if ($urandom_range(0, 1) == 1)
            s1[g] = W'(1 << $urandom_range(0, W - 1));
          else
            s0[g] = W'(1 << $urandom_range(0, W - 1));
        end
        txn(g, W'($urandom), hold,
            chkon(g) && $urandom_range(0, 3) == 0);
        if (!hold) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      s1[g] = '0;
      s0[g] = '0;
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
